// File: rtl/polaris_pkg.sv
// +----------------------------------------------------------------------+
// | polaris_pkg : shared encodings, states and helpers for polaris_cpu   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package polaris_pkg;

  localparam logic [63:0] RESET_VECTOR_DEFAULT = 64'hFFFF_FFFF_FFFF_FF00;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM32  = 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Low two funct3 bits select the CSR operation; bit 2 selects the uimm form.
  localparam logic [1:0] F3_CSRRW = 2'b01;
  localparam logic [1:0] F3_CSRRS = 2'b10;
  localparam logic [1:0] F3_CSRRC = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_MEM     = 2'd2,
    ST_CSR     = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt,
                                         input logic is_reg);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] siz);
    case (siz)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] load_ext(input logic [2:0] f3, input logic [63:0] d);
    case (f3)
      F3_LB:   return {{56{d[7]}}, d[7:0]};
      F3_LH:   return {{48{d[15]}}, d[15:0]};
      F3_LW:   return {{32{d[31]}}, d[31:0]};
      F3_LBU:  return {56'b0, d[7:0]};
      F3_LHU:  return {48'b0, d[15:0]};
      F3_LWU:  return {32'b0, d[31:0]};
      default: return d;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/polaris_alu.sv
// +----------------------------------------------------------------------+
// | polaris_alu : integer ALU with 64-bit and 32-bit (W) operating modes |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module polaris_alu
  import polaris_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  alu_op_e     op_i,
  input  logic        w32_i,
  output logic [63:0] y_o
);

  logic [5:0]  w_shamt;
  logic [63:0] w_a_zx;
  logic [63:0] w_a_sx;
  logic [63:0] w_r;

  always_comb begin
    // W mode shifts see only the low word of the operand and a 5-bit amount.
    w_shamt = w32_i ? {1'b0, b_i[4:0]} : b_i[5:0];
    w_a_zx  = w32_i ? {32'b0, a_i[31:0]} : a_i;
    w_a_sx  = w32_i ? {{32{a_i[31]}}, a_i[31:0]} : a_i;
    case (op_i)
      ALU_ADD:  w_r = a_i + b_i;
      ALU_SUB:  w_r = a_i - b_i;
      ALU_SLL:  w_r = a_i << w_shamt;
      ALU_SLT:  w_r = {63'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: w_r = {63'b0, a_i < b_i};
      ALU_XOR:  w_r = a_i ^ b_i;
      ALU_SRL:  w_r = w_a_zx >> w_shamt;
      ALU_SRA:  w_r = $unsigned($signed(w_a_sx) >>> w_shamt);
      ALU_OR:   w_r = a_i | b_i;
      ALU_AND:  w_r = a_i & b_i;
      default:  w_r = '0;
    endcase
    y_o = w32_i ? {{32{w_r[31]}}, w_r[31:0]} : w_r;
  end

endmodule

`default_nettype wire

// File: rtl/polaris_cpu.sv
// +----------------------------------------------------------------------+
// | polaris_cpu : multi-cycle RV64I core (FETCH/EXECUTE/MEM/CSR)         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module polaris_cpu
  import polaris_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        irq_i,
  output logic [63:0] iadr_o,
  output logic        istb_o,
  input  logic        iack_i,
  input  logic [31:0] idat_i,
  output logic [63:0] dadr_o,
  output logic        dstb_o,
  output logic        dwe_o,
  output logic [1:0]  dsiz_o,
  output logic [63:0] ddat_o,
  input  logic        dack_i,
  input  logic [63:0] ddat_i,
  output logic [11:0] cadr_o,
  output logic        coe_o,
  output logic        cwe_o,
  input  logic        cvalid_i,
  output logic [63:0] cdat_o,
  input  logic [63:0] cdat_i
);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q;
  logic        run_q;
  logic [63:0] rf_q [0:31];

  logic [6:0]  w_opc;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [63:0] w_rs1_val, w_rs2_val;
  logic [63:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [63:0] w_pc4, w_mem_adr, w_csr_src, w_csr_new;
  logic        w_is_reg, w_is_store, w_take, w_csr_we;
  logic [63:0] w_alu_y;
  alu_op_e     w_alu_op;
  logic        w_rf_we;
  logic [63:0] w_rf_wdata;
  logic        w_unused;

  assign w_unused = irq_i;

  assign w_opc = ir_q[6:0];
  assign w_rd  = ir_q[11:7];
  assign w_f3  = ir_q[14:12];
  assign w_rs1 = ir_q[19:15];
  assign w_rs2 = ir_q[24:20];

  assign w_rs1_val = (w_rs1 == 5'd0) ? 64'd0 : rf_q[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 64'd0 : rf_q[w_rs2];

  assign w_imm_i = {{52{ir_q[31]}}, ir_q[31:20]};
  assign w_imm_s = {{52{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign w_imm_b = {{51{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign w_imm_u = {{32{ir_q[31]}}, ir_q[31:12], 12'b0};
  assign w_imm_j = {{43{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  assign w_pc4      = pc_q + 64'd4;
  assign w_is_store = (w_opc == OPC_STORE);
  assign w_mem_adr  = w_rs1_val + (w_is_store ? w_imm_s : w_imm_i);
  assign w_is_reg   = (w_opc == OPC_OP) || (w_opc == OPC_OP32);
  assign w_alu_op   = alu_decode(w_f3, ir_q[30], w_is_reg);

  polaris_alu u_alu (
    .a_i   (w_rs1_val),
    .b_i   (w_is_reg ? w_rs2_val : w_imm_i),
    .op_i  (w_alu_op),
    .w32_i ((w_opc == OPC_IMM32) || (w_opc == OPC_OP32)),
    .y_o   (w_alu_y)
  );

  always_comb begin
    case (w_f3)
      F3_BEQ:  w_take = (w_rs1_val == w_rs2_val);
      F3_BNE:  w_take = (w_rs1_val != w_rs2_val);
      F3_BLT:  w_take = ($signed(w_rs1_val) < $signed(w_rs2_val));
      F3_BGE:  w_take = ($signed(w_rs1_val) >= $signed(w_rs2_val));
      F3_BLTU: w_take = (w_rs1_val < w_rs2_val);
      F3_BGEU: w_take = (w_rs1_val >= w_rs2_val);
      default: w_take = 1'b0;
    endcase
  end

  // Set/clear with a zero source field is a pure read and must not write the CSR.
  assign w_csr_src = w_f3[2] ? {59'b0, w_rs1} : w_rs1_val;
  assign w_csr_we  = cvalid_i && !(w_f3[1] && (w_rs1 == 5'd0));
  always_comb begin
    case (w_f3[1:0])
      F3_CSRRS: w_csr_new = cdat_i | w_csr_src;
      F3_CSRRC: w_csr_new = cdat_i & ~w_csr_src;
      default:  w_csr_new = w_csr_src;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    w_rf_we    = 1'b0;
    w_rf_wdata = 64'd0;
    istb_o     = 1'b0;
    dadr_o     = 64'd0;
    dstb_o     = 1'b0;
    dwe_o      = 1'b0;
    dsiz_o     = 2'd0;
    ddat_o     = 64'd0;
    cadr_o     = 12'd0;
    coe_o      = 1'b0;
    cwe_o      = 1'b0;
    cdat_o     = 64'd0;
    case (state_q)
      ST_FETCH: begin
        istb_o = run_q;
        if (run_q && iack_i) state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        pc_d    = w_pc4;
        case (w_opc)
          OPC_LUI:   begin w_rf_we = 1'b1; w_rf_wdata = w_imm_u; end
          OPC_AUIPC: begin w_rf_we = 1'b1; w_rf_wdata = pc_q + w_imm_u; end
          OPC_JAL: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = w_pc4;
            pc_d       = pc_q + w_imm_j;
          end
          OPC_JALR: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = w_pc4;
            pc_d       = (w_rs1_val + w_imm_i) & ~64'd1;
          end
          OPC_BRANCH: if (w_take) pc_d = pc_q + w_imm_b;
          OPC_LOAD, OPC_STORE: begin
            state_d = ST_MEM;
            pc_d    = pc_q;
          end
          OPC_IMM, OPC_OP, OPC_IMM32, OPC_OP32: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = w_alu_y;
          end
          OPC_SYSTEM: if (w_f3[1:0] != 2'b00) begin
            state_d = ST_CSR;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        dadr_o = w_mem_adr;
        dstb_o = 1'b1;
        dwe_o  = w_is_store;
        dsiz_o = w_f3[1:0];
        ddat_o = w_is_store ? (w_rs2_val & size_mask(w_f3[1:0])) : 64'd0;
        if (dack_i) begin
          w_rf_we    = !w_is_store;
          w_rf_wdata = load_ext(w_f3, ddat_i);
          pc_d       = w_pc4;
          state_d    = ST_FETCH;
        end
      end
      ST_CSR: begin
        cadr_o     = ir_q[31:20];
        coe_o      = (w_rd != 5'd0);
        cwe_o      = w_csr_we;
        cdat_o     = w_csr_new;
        w_rf_we    = 1'b1;
        w_rf_wdata = cvalid_i ? cdat_i : 64'd0;
        pc_d       = w_pc4;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign iadr_o = pc_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_VECTOR;
      ir_q    <= 32'd0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      run_q   <= 1'b1;
      if (state_q == ST_FETCH && run_q && iack_i) ir_q <= idat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_rf_we && (w_rd != 5'd0)) rf_q[w_rd] <= w_rf_wdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_polaris_cpu.sv
// +----------------------------------------------------------------------+
// | tb_polaris_cpu : scoreboard bench for polaris_cpu                    |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_polaris_cpu;

  logic        clk_i = 1'b0;
  logic        reset_i, irq_i, iack_man, tie_mode, dack_i, cvalid_i;
  logic [31:0] idat_i;
  logic [63:0] ddat_i, cdat_i;
  wire  logic  iack_i;
  logic [63:0] iadr_o, dadr_o, ddat_o, cdat_o;
  logic        istb_o, dstb_o, dwe_o, coe_o, cwe_o;
  logic [1:0]  dsiz_o;
  logic [11:0] cadr_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] pc_exp;
  logic [63:0] ld_data;

  typedef struct {
    int          kind;  // 0 load, 1 store, 2 csr
    logic [63:0] adr;
    logic [63:0] dat;
    logic [1:0]  siz;
    logic        we;
    logic        oe;
  } exp_t;
  exp_t sb_q[$];

  assign iack_i = tie_mode ? istb_o : iack_man;

  polaris_cpu dut (
    .clk_i(clk_i), .reset_i(reset_i), .irq_i(irq_i),
    .iadr_o(iadr_o), .istb_o(istb_o), .iack_i(iack_i), .idat_i(idat_i),
    .dadr_o(dadr_o), .dstb_o(dstb_o), .dwe_o(dwe_o), .dsiz_o(dsiz_o),
    .ddat_o(ddat_o), .dack_i(dack_i), .ddat_i(ddat_i),
    .cadr_o(cadr_o), .coe_o(coe_o), .cwe_o(cwe_o), .cvalid_i(cvalid_i),
    .cdat_o(cdat_o), .cdat_i(cdat_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input int op);
    logic [11:0] im;
    im = imm[11:0];
    return {im, rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1,
                                        input int f3);
    logic [11:0] im;
    im = imm[11:0];
    return {im[11:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd, input int op);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                        input int f3);
    logic [12:0] b;
    b = imm[12:0];
    return {b[12], b[10:5], rs2[4:0], rs1[4:0], f3[2:0], b[4:1], b[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] j;
    j = imm[20:0];
    return {j[20], j[10:1], j[11], j[19:12], rd[4:0], 7'h6F};
  endfunction

  task automatic push(input int kind, input logic [63:0] adr, input logic [63:0] dat,
                      input logic [1:0] siz, input logic we, input logic oe);
    exp_t e;
    e.kind = kind; e.adr = adr; e.dat = dat; e.siz = siz; e.we = we; e.oe = oe;
    sb_q.push_back(e);
  endtask

  task automatic service_mem();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty_mem", 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      check("d_kind", 64'(e.kind), dwe_o ? 64'd1 : 64'd0);
      check("dadr", dadr_o, e.adr);
      check("dsiz", 64'(dsiz_o), 64'(e.siz));
      if (e.we) check("ddat", ddat_o, e.dat);
    end
    ddat_i = ld_data;
    dack_i = 1'b1;
  endtask

  task automatic service_csr();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty_csr", 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      check("c_kind", 64'(e.kind), 64'd2);
      check("cadr", 64'(cadr_o), e.adr);
      check("coe", 64'(coe_o), 64'(e.oe));
      check("cwe", 64'(cwe_o), 64'(e.we));
      if (e.we) check("cdat", cdat_o, e.dat);
    end
  endtask

  // Services data/CSR traffic until the next fetch strobe, then checks its address.
  task automatic wait_fetch(input logic [63:0] pc);
    int n;
    n = 0;
    forever begin
      @(negedge clk_i);
      dack_i = 1'b0;
      check("strobe_excl",
            64'($countones({istb_o, dstb_o, coe_o | cwe_o}) <= 1), 64'd1);
      if (istb_o) begin
        check("iadr", iadr_o, pc);
        return;
      end
      if (dstb_o) service_mem();
      else if (coe_o || cwe_o) service_csr();
      n++;
      if (n > 40) begin
        check("fetch_timeout", 64'd0, 64'd1);
        return;
      end
    end
  endtask

  task automatic give(input logic [31:0] instr, input int delay);
    logic [63:0] a0;
    a0 = iadr_o;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk_i);
      check("istb_hold", 64'(istb_o), 64'd1);
      check("iadr_hold", iadr_o, a0);
    end
    idat_i   = instr;
    iack_man = 1'b1;
    @(negedge clk_i);
    iack_man = 1'b0;
  endtask

  task automatic step(input logic [31:0] instr);
    wait_fetch(pc_exp);
    give(instr, 0);
    pc_exp = pc_exp + 64'd4;
  endtask

  task automatic do_reset(input logic do_check);
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    if (do_check) begin
      check("rst_istb", 64'(istb_o), 64'd0);
      check("rst_dstb", 64'(dstb_o), 64'd0);
      check("rst_cstb", 64'(coe_o | cwe_o), 64'd0);
      check("rst_dadr", dadr_o, 64'd0);
      check("rst_ddat", ddat_o, 64'd0);
      check("rst_cdat", cdat_o, 64'd0);
    end
    reset_i = 1'b0;
    #1;
    if (do_check) check("istb_post_rst", 64'(istb_o), 64'd0);
    pc_exp = 64'hFFFF_FFFF_FFFF_FF00;
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] AS   = 64'h4141_4141_4141_4141;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  initial begin
    reset_i = 1'b1; irq_i = 1'b0; iack_man = 1'b0; tie_mode = 1'b1;
    dack_i = 1'b0; cvalid_i = 1'b1; idat_i = NOP; ddat_i = '0; cdat_i = '0;
    ld_data = '0; pc_exp = '0;

    // Reset behaviour and free-running fetch with acknowledge tied to strobe.
    do_reset(1'b1);
    wait_fetch(64'hFFFF_FFFF_FFFF_FF00);
    wait_fetch(64'hFFFF_FFFF_FFFF_FF04);

    // ALU, load/store and CSR program.
    tie_mode = 1'b0;
    do_reset(1'b0);
    step(enc_i(-1, 0, 0, 1, 7'h13));                  // ADDI  x1,x0,-1
    step(enc_i(60, 1, 5, 2, 7'h13));                  // SRLI  x2,x1,60
    push(1, 64'd0, 64'hF, 2'd3, 1'b1, 1'b0);
    step(enc_s(0, 2, 0, 3));                          // SD    x2,0(x0)
    step(enc_i(-1, 0, 0, 3, 7'h1B));                  // ADDIW x3,x0,-1
    push(1, 64'd8, ONES, 2'd3, 1'b1, 1'b0);
    step(enc_s(8, 3, 0, 3));                          // SD    x3,8(x0)
    ld_data = AS;
    push(0, 64'd0, 64'd0, 2'd3, 1'b0, 1'b0);
    step(enc_i(0, 0, 3, 4, 7'h03));                   // LD    x4,0(x0)
    push(1, 64'd16, AS, 2'd3, 1'b1, 1'b0);
    step(enc_s(16, 4, 0, 3));                         // SD    x4,16(x0)
    push(0, 64'd1, 64'd0, 2'd0, 1'b0, 1'b0);
    step(enc_i(1, 0, 0, 6, 7'h03));                   // LB    x6,1(x0)
    push(1, 64'd24, 64'h41, 2'd3, 1'b1, 1'b0);
    step(enc_s(24, 6, 0, 3));                         // SD    x6,24(x0)
    cvalid_i = 1'b1; cdat_i = 64'd7;
    push(2, 64'h0FF, AS, 2'd0, 1'b1, 1'b1);
    step(enc_i(12'h0FF, 4, 1, 5, 7'h73));             // CSRRW x5,0x0FF,x4
    push(1, 64'd32, 64'd7, 2'd3, 1'b1, 1'b0);
    step(enc_s(32, 5, 0, 3));                         // SD    x5,32(x0)
    cvalid_i = 1'b0;
    push(2, 64'h0FF, 64'd0, 2'd0, 1'b0, 1'b1);
    step(enc_i(12'h0FF, 4, 1, 5, 7'h73));             // CSRRW x5,0x0FF,x4 (invalid)
    push(1, 64'd40, 64'd0, 2'd3, 1'b1, 1'b0);
    step(enc_s(40, 5, 0, 3));                         // SD    x5,40(x0)
    step(enc_r(7'h20, 2, 0, 0, 7, 7'h33));            // SUB   x7,x0,x2
    push(1, 64'd48, 64'h0000_0000_FFFF_FFF1, 2'd2, 1'b1, 1'b0);
    step(enc_s(48, 7, 0, 2));                         // SW    x7,48(x0)
    step(enc_i(12'h402, 7, 5, 9, 7'h13));             // SRAI  x9,x7,2
    push(1, 64'd56, 64'hFFFF_FFFF_FFFF_FFFC, 2'd3, 1'b1, 1'b0);
    step(enc_s(56, 9, 0, 3));                         // SD    x9,56(x0)
    step(enc_r(0, 2, 0, 3, 10, 7'h33));               // SLTU  x10,x0,x2
    push(1, 64'd64, 64'd1, 2'd1, 1'b1, 1'b0);
    step(enc_s(64, 10, 0, 1));                        // SH    x10,64(x0)
    step(enc_i(31, 1, 1, 13, 7'h1B));                 // SLLIW x13,x1,31
    push(1, 64'd72, 64'hFFFF_FFFF_8000_0000, 2'd3, 1'b1, 1'b0);
    step(enc_s(72, 13, 0, 3));                        // SD    x13,72(x0)
    ld_data = 64'h0000_0000_0000_0080;
    push(0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0);
    step(enc_i(0, 0, 0, 14, 7'h03));                  // LB    x14,0(x0)
    push(1, 64'd80, 64'hFFFF_FFFF_FFFF_FF80, 2'd3, 1'b1, 1'b0);
    step(enc_s(80, 14, 0, 3));                        // SD    x14,80(x0)
    cvalid_i = 1'b1; cdat_i = 64'd7;
    push(2, 64'h300, 64'd2, 2'd0, 1'b1, 1'b1);
    step(enc_i(12'h300, 5, 7, 15, 7'h73));            // CSRRCI x15,0x300,5
    push(1, 64'd88, 64'd7, 2'd3, 1'b1, 1'b0);
    step(enc_s(88, 15, 0, 3));                        // SD    x15,88(x0)
    step(enc_b(8, 2, 0, 1));                          // BNE   x0,x2,+8
    pc_exp = pc_exp + 64'd4;
    push(1, 64'd96, ONES, 2'd3, 1'b1, 1'b0);
    step(enc_s(96, 1, 0, 3));                         // SD    x1,96(x0)
    wait_fetch(pc_exp);

    // Backward branch, stalled fetch, JAL link.
    do_reset(1'b0);
    step(NOP);
    step(NOP);
    step(enc_b(-8, 0, 0, 0));                         // BEQ   x0,x0,-8
    wait_fetch(64'hFFFF_FFFF_FFFF_FF00);
    give(enc_j(8, 8), 5);                             // JAL   x8,+8 after 5 stall cycles
    pc_exp = 64'hFFFF_FFFF_FFFF_FF08;
    push(1, 64'd0, 64'hFFFF_FFFF_FFFF_FF04, 2'd3, 1'b1, 1'b0);
    step(enc_s(0, 8, 0, 3));                          // SD    x8,0(x0)
    wait_fetch(pc_exp);

    // Reset during a load must abort it without touching the destination.
    do_reset(1'b0);
    step(enc_i(5, 0, 0, 16, 7'h13));                  // ADDI  x16,x0,5
    step(enc_i(0, 0, 3, 16, 7'h03));                  // LD    x16,0(x0)
    @(negedge clk_i);
    check("abort_pre_dstb", 64'(dstb_o), 64'd1);
    ddat_i  = ONES;
    reset_i = 1'b1;
    #1;
    check("abort_dstb", 64'(dstb_o), 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    pc_exp  = 64'hFFFF_FFFF_FFFF_FF00;
    push(1, 64'd0, 64'd5, 2'd3, 1'b1, 1'b0);
    step(enc_s(0, 16, 0, 3));                         // SD    x16,0(x0)
    wait_fetch(pc_exp);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/polaris_cpu.md
POLARIS_CPU -- requirements
Module: polaris_cpu

Interface
REQ-001 Parameter RESET_VECTOR, default 64'hFFFF_FFFF_FFFF_FF00, first fetch address after reset.
REQ-002 clk_i  in  1  single clock; all state changes on rising edge.
REQ-003 reset_i  in  1  reset; asynchronous, active-high.
REQ-004 irq_i  in  1  interrupt request; reserved, ignored in this revision.
REQ-005 iadr_o  out  64  instruction fetch address.
REQ-006 istb_o  out  1  fetch strobe; high while a fetch is pending.
REQ-007 iack_i  in  1  fetch acknowledge; idat_i valid when high.
REQ-008 idat_i  in  32  instruction word.
REQ-009 dadr_o  out  64  data address.
REQ-010 dstb_o  out  1  data strobe.
REQ-011 dwe_o  out  1  data write enable (1 = store).
REQ-012 dsiz_o  out  2  access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-013 ddat_o  out  64  store data, right-aligned.
REQ-014 dack_i  in  1  data acknowledge; ddat_i valid on loads when high.
REQ-015 ddat_i  in  64  load data, right-aligned.
REQ-016 cadr_o  out  12  CSR address (instruction bits 31:20).
REQ-017 coe_o  out  1  CSR read enable.
REQ-018 cwe_o  out  1  CSR write enable.
REQ-019 cvalid_i  in  1  CSR address implemented.
REQ-020 cdat_o  out  64  CSR write data.
REQ-021 cdat_i  in  64  CSR read data.

Function
REQ-022 SHALL implement RV64I integer subset: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, loads LB/LH/LW/LD/LBU/LHU/LWU, stores SB/SH/SW/SD, OP-IMM, OP, OP-IMM-32, OP-32, CSRRW/CSRRS/CSRRC and immediate forms.
REQ-023 SHALL be multi-cycle FSM with states FETCH, EXECUTE, MEM, CSR; FETCH->EXECUTE on iack_i; EXECUTE->MEM for load/store, ->CSR for SYSTEM CSR ops, else ->FETCH.
REQ-024 FETCH: iadr_o=PC, istb_o=1 each cycle until iack_i; idat_i latched on iack_i cycle.
REQ-025 MEM: dstb_o=1 until dack_i; load result sign/zero-extended from ddat_i and written to rd on dack_i cycle.
REQ-026 CSR: coe_o=1 if rd!=0, cwe_o=1 unless CSRRS/CSRRC with rs1/uimm=0; single cycle; cdat_o = new value (write, cdat_i|src, cdat_i&~src).
REQ-027 If cvalid_i=0 during CSR state, cwe_o SHALL be forced 0 and rd written with 0.
REQ-028 Register x0 SHALL read 0; writes to x0 discarded; 31 other 64-bit registers.
REQ-029 PC advances by 4; branches/JAL use PC+imm; JALR target (rs1+imm)&~1; link = PC+4.
REQ-030 *W ops SHALL compute 32-bit result sign-extended to 64; shift amounts 6 bits (64-bit) / 5 bits (W).
REQ-031 Unrecognised opcodes SHALL execute as NOP (PC+4).
REQ-032 Strobes (istb_o, dstb_o, coe_o, cwe_o) SHALL never be high simultaneously.

Reset
REQ-033 On reset_i: PC=RESET_VECTOR, state FETCH, istb_o=0 until first cycle after release, all other strobes 0, dadr_o/ddat_o/cdat_o=0.
REQ-034 Reset mid-fetch or mid-MEM SHALL abort the transaction without register write.
REQ-035 General registers SHALL not require reset.

Structure
REQ-036 Opcode, funct3, state encodings and RESET_VECTOR default SHALL live in shared package polaris_pkg.
REQ-037 ALU SHALL be one sub-module polaris_alu (add/sub/shift/logic/compare, 32-bit mode flag).

Verification
REQ-038 Reset 3 cycles, iack_i tied to istb_o -> first iadr_o=FFFF_FFFF_FFFF_FF00, next FF04.
REQ-039 ADDI x1,x0,-1 then SRLI x2,x1,60 -> x2=0xF; ADDIW x3,x0,-1 -> x3=FFFF_FFFF_FFFF_FFFF.
REQ-040 LD x4,0(x0) with ddat_i=4141_4141_4141_4141, dack_i=1 -> x4=4141_4141_4141_4141; LB -> 0x41.
REQ-041 CSRRW x5,0x0FF,x4 with cvalid_i=1, cdat_i=7 -> cadr_o=0x0FF, cdat_o=4141..41, x5=7; with cvalid_i=0 -> cwe_o=0, x5=0.
REQ-042 BEQ x0,x0,-8 at PC FF08 -> next iadr_o FF00; iack_i held low 5 cycles -> istb_o stays high, iadr_o stable.
